// File: rtl/accum_buffer_if.sv
// Update-request and read-port bundle for accum_buffer.
// The master drives requests; the slave (the buffer) answers with ready and read data.
interface accum_buffer_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned VEC_WIDTH  = 384
);
    logic                  valid;
    logic                  ready;
    logic                  mode;
    logic [ADDR_WIDTH-1:0] addr;
    logic [VEC_WIDTH-1:0]  data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr_rd;
    logic                  rd_valid;
    logic [VEC_WIDTH-1:0]  data_rd;

    modport master (
        output valid, mode, addr, data, rd_en, addr_rd,
        input  ready, rd_valid, data_rd
    );

    modport slave (
        input  valid, mode, addr, data, rd_en, addr_rd,
        output ready, rd_valid, data_rd
    );
endinterface

// File: rtl/accum_buffer.sv
// Multi-lane partial-sum buffer: overwrite/accumulate entries through a 2-stage forwarded pipeline.
// Define ACC_SAT_EN for saturating lanes with a sticky o_sat; otherwise lanes wrap and o_sat is 0.
module accum_buffer #(
    parameter int unsigned LANES      = 24,
    parameter int unsigned LANE_WIDTH = 16,
    parameter int unsigned ENTRY_NUM  = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(ENTRY_NUM)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    accum_buffer_if.slave bus,
    input  logic          i_clear,
    output logic          o_busy,
    output logic          o_sat
);
    localparam int unsigned VEC_WIDTH = LANES * LANE_WIDTH;
    localparam logic [ADDR_WIDTH:0] ENTRY_LIM = (ADDR_WIDTH + 1)'(ENTRY_NUM);

    typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

    state_e state_q, state_d;
    logic   clear_all;
    logic   accept;
    logic   upd_in_range;
    logic   rd_in_range;

    logic [VEC_WIDTH-1:0] mem_q [ENTRY_NUM];

    logic                  s1_valid_q;
    logic                  s1_mode_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [VEC_WIDTH-1:0]  s1_data_q;
    logic [VEC_WIDTH-1:0]  s1_old;

    logic                  s2_valid_q;
    logic                  s2_mode_q;
    logic [ADDR_WIDTH-1:0] s2_addr_q;
    logic [VEC_WIDTH-1:0]  s2_data_q;
    logic [VEC_WIDTH-1:0]  s2_old_q;
    logic [VEC_WIDTH-1:0]  s2_new;
    logic [LANE_WIDTH-1:0] lane_res;

    logic                  rd_valid_q;
    logic [VEC_WIDTH-1:0]  data_rd_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_clear) state_d = StDrain;
            StDrain: if (!s1_valid_q && !s2_valid_q) state_d = StClear;
            StClear: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.ready = 1'b0;
        o_busy    = 1'b0;
        clear_all = 1'b0;
        unique case (state_q)
            StIdle:  bus.ready = 1'b1;
            StDrain: o_busy = 1'b1;
            StClear: begin
                o_busy    = 1'b1;
                clear_all = 1'b1;
            end
            default: bus.ready = 1'b0;
        endcase
    end

    assign accept       = bus.valid && bus.ready;
    assign upd_in_range = {1'b0, bus.addr} < ENTRY_LIM;
    assign rd_in_range  = {1'b0, bus.addr_rd} < ENTRY_LIM;

    // Stage 1 captures the request; out-of-range addresses never enter the pipe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= accept && upd_in_range;
            if (accept) begin
                s1_mode_q <= bus.mode;
                s1_addr_q <= bus.addr;
                s1_data_q <= bus.data;
            end
        end
    end

    // A commit landing on the same edge would make the memory value stale.
    assign s1_old = (s2_valid_q && (s2_addr_q == s1_addr_q)) ? s2_new : mem_q[s1_addr_q];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid_q <= 1'b0;
            s2_mode_q  <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
            s2_old_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_mode_q <= s1_mode_q;
                s2_addr_q <= s1_addr_q;
                s2_data_q <= s1_data_q;
                s2_old_q  <= s1_old;
            end
        end
    end

`ifdef ACC_SAT_EN
    logic                  s2_sat;
    logic [LANE_WIDTH:0]   lane_sum;

    always_comb begin
        s2_new   = '0;
        s2_sat   = 1'b0;
        lane_sum = '0;
        lane_res = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = {s2_old_q[k*LANE_WIDTH+LANE_WIDTH-1], s2_old_q[k*LANE_WIDTH +: LANE_WIDTH]}
                     + {s2_data_q[k*LANE_WIDTH+LANE_WIDTH-1], s2_data_q[k*LANE_WIDTH +: LANE_WIDTH]};
            if (!s2_mode_q) begin
                lane_res = s2_data_q[k*LANE_WIDTH +: LANE_WIDTH];
            end else if (lane_sum[LANE_WIDTH] != lane_sum[LANE_WIDTH-1]) begin
                lane_res = lane_sum[LANE_WIDTH] ? {1'b1, {(LANE_WIDTH-1){1'b0}}}
                                                : {1'b0, {(LANE_WIDTH-1){1'b1}}};
                s2_sat   = 1'b1;
            end else begin
                lane_res = lane_sum[LANE_WIDTH-1:0];
            end
            s2_new[k*LANE_WIDTH +: LANE_WIDTH] = lane_res;
        end
    end

    logic sat_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sat_q <= 1'b0;
        end else if (clear_all) begin
            sat_q <= 1'b0;
        end else if (s2_valid_q && s2_sat) begin
            sat_q <= 1'b1;
        end
    end

    assign o_sat = sat_q;
`else
    always_comb begin
        s2_new   = '0;
        lane_res = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_res = s2_mode_q ? s2_old_q[k*LANE_WIDTH +: LANE_WIDTH]
                                   + s2_data_q[k*LANE_WIDTH +: LANE_WIDTH]
                                 : s2_data_q[k*LANE_WIDTH +: LANE_WIDTH];
            s2_new[k*LANE_WIDTH +: LANE_WIDTH] = lane_res;
        end
    end

    assign o_sat = 1'b0;
`endif

    // Clear only runs once the pipe is drained, so it never races a commit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) mem_q[i] <= '0;
        end else if (clear_all) begin
            for (int i = 0; i < ENTRY_NUM; i++) mem_q[i] <= '0;
        end else if (s2_valid_q) begin
            mem_q[s2_addr_q] <= s2_new;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_valid_q <= 1'b0;
            data_rd_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                data_rd_q <= rd_in_range ? mem_q[bus.addr_rd] : '0;
            end
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.data_rd  = data_rd_q;
endmodule

// File: tb/tb_accum_buffer.sv
// Randomized bench for accum_buffer against a lane-level behavioural model of the buffer.
module tb_accum_buffer;
    localparam int LANES = 24;
    localparam int LW    = 16;
    localparam int EN    = 16;
    localparam int AW    = 4;
    localparam int VW    = LANES * LW;
`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic busy;
    logic sat;

    accum_buffer_if #(.ADDR_WIDTH(AW), .VEC_WIDTH(VW)) bus ();

    accum_buffer #(
        .LANES      (LANES),
        .LANE_WIDTH (LW),
        .ENTRY_NUM  (EN),
        .ADDR_WIDTH (AW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .i_clear (clear),
        .o_busy  (busy),
        .o_sat   (sat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: per-lane integer memory, queue of updates each tagged with its commit edge.
    typedef struct {
        int             e;
        int             a;
        bit             mode;
        logic [VW-1:0]  d;
    } upd_t;

    logic signed [LW-1:0] mm [EN][LANES];
    upd_t          pq [$];
    bit            msat      = 1'b0;
    bit            exp_ready = 1'b1;
    bit            exp_busy  = 1'b0;
    bit            exp_rdv   = 1'b0;
    logic [VW-1:0] exp_rdd   = '0;
    bit            clr_on    = 1'b0;
    int            clr_edge  = 0;
    int            n         = 0;

    function automatic logic [VW-1:0] mvec(input int a);
        logic [VW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*LW +: LW] = mm[a][k];
        return r;
    endfunction

    function automatic logic [VW-1:0] rep(input int v);
        logic [VW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*LW +: LW] = 16'(v);
        return r;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < EN; a++)
            for (int k = 0; k < LANES; k++) mm[a][k] = '0;
        pq.delete();
        msat = 0; exp_ready = 1; exp_busy = 0; exp_rdv = 0; exp_rdd = '0; clr_on = 0;
    endtask

    task automatic apply(input upd_t u);
        for (int k = 0; k < LANES; k++) begin
            int b;
            int v;
            b = int'($signed(u.d[k*LW +: LW]));
            if (!u.mode) begin
                v = b;
            end else begin
                v = int'(mm[u.a][k]) + b;
                if (SAT && v > 32767) begin
                    v = 32767; msat = 1;
                end else if (SAT && v < -32768) begin
                    v = -32768; msat = 1;
                end
            end
            mm[u.a][k] = 16'(v);
        end
    endtask

    initial begin
        upd_t u;
        int   lc;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                n++;
                exp_rdv = bus.rd_en;
                if (bus.rd_en) exp_rdd = mvec(int'(bus.addr_rd));
                if (bus.valid && exp_ready) begin
                    u.e = n + 2; u.a = int'(bus.addr); u.mode = bus.mode; u.d = bus.data;
                    pq.push_back(u);
                end
                if (clear && exp_ready) begin
                    lc = n;
                    foreach (pq[i]) if (pq[i].e > lc) lc = pq[i].e;
                    clr_on   = 1;
                    clr_edge = lc + 2;
                end
                while (pq.size() > 0 && pq[0].e == n) apply(pq.pop_front());
                if (clr_on && n == clr_edge) begin
                    for (int a = 0; a < EN; a++)
                        for (int k = 0; k < LANES; k++) mm[a][k] = '0;
                    msat   = 0;
                    clr_on = 0;
                end
                exp_ready = !clr_on;
                exp_busy  = clr_on;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", VW'(bus.ready), VW'(exp_ready));
        chk("busy", VW'(busy), VW'(exp_busy));
        chk("sat", VW'(sat), VW'(msat));
        chk("rd_valid", VW'(bus.rd_valid), VW'(exp_rdv));
        if (exp_rdv || !rst_n) chk("data_rd", bus.data_rd, exp_rdd);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int c);
        repeat (c) cyc();
    endtask

    task automatic upd(input bit mode, input int a, input logic [VW-1:0] d);
        bus.valid = 1; bus.mode = mode; bus.addr = AW'(a); bus.data = d;
        cyc();
        bus.valid = 0;
    endtask

    task automatic rd_lit(input int a, input logic [VW-1:0] exp, input string name);
        bus.rd_en = 1; bus.addr_rd = AW'(a);
        cyc();
        bus.rd_en = 0;
        chk({name, "_valid"}, VW'(bus.rd_valid), VW'(1));
        chk(name, bus.data_rd, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] v;
        logic [VW-1:0] e;
        int            low;
        bus.valid = 0; bus.mode = 0; bus.addr = '0; bus.data = '0;
        bus.rd_en = 0; bus.addr_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", VW'(bus.ready), VW'(1));
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_sat", VW'(sat), VW'(0));
        chk("rst_rd_valid", VW'(bus.rd_valid), VW'(0));
        chk("rst_data_rd", bus.data_rd, VW'(0));
        rst_n = 1;
        idle(2);

        // Back-to-back accumulates to one entry through the forward path
        upd(0, 3, rep(5));
        upd(1, 3, rep(7));
        upd(1, 3, rep(-2));
        idle(2);
        rd_lit(3, rep(10), "fwd_e3");

        v = '0; v[15:0] = 16'h7FF0; upd(0, 0, v);
        v[15:0] = 16'h0020; upd(1, 0, v);
        idle(2);
        e = '0; e[15:0] = SAT ? 16'h7FFF : 16'h8010;
        rd_lit(0, e, "sat_pos");
        chk("sat_flag_pos", VW'(sat), VW'(SAT));
        v[15:0] = 16'h8000; upd(0, 1, v);
        v[15:0] = 16'hFFFF; upd(1, 1, v);
        idle(2);
        e[15:0] = SAT ? 16'h8000 : 16'h7FFF;
        rd_lit(1, e, "sat_neg");

        // Read on the commit edge sees the old contents
        upd(0, 5, rep(16'h1111));
        idle(2);
        upd(0, 5, rep(16'h2222));
        idle(1);
        bus.rd_en = 1; bus.addr_rd = 4'd5;
        cyc();
        chk("rbw_old", bus.data_rd, rep(16'h1111));
        cyc();
        chk("rbw_new", bus.data_rd, rep(16'h2222));
        bus.rd_en = 0;

        upd(1, 1, rep(3));
        bus.valid = 1; bus.mode = 1; bus.addr = 4'd2; bus.data = rep(4); clear = 1;
        cyc();
        bus.valid = 0; clear = 0;
        low = 0;
        for (int i = 0; i < 20 && !bus.ready; i++) begin
            low++;
            cyc();
        end
        chk("clear_ready_back", VW'(bus.ready), VW'(1));
        chk("clear_ready_low_ge3", VW'(low >= 3), VW'(1));
        for (int a = 0; a < EN; a++) rd_lit(a, '0, "clear_entry");
        chk("clear_sat", VW'(sat), VW'(0));

        // Request held through drain/clear must land exactly once
        clear = 1;
        cyc();
        clear = 0;
        bus.valid = 1; bus.mode = 1; bus.addr = 4'd4; bus.data = rep(1);
        low = 0;
        for (int i = 0; i < 20 && !bus.ready; i++) begin
            low++;
            cyc();
        end
        chk("bp_blocked_ge2", VW'(low >= 2), VW'(1));
        cyc();
        bus.valid = 0;
        idle(4);
        rd_lit(4, rep(1), "bp_once");

        for (int i = 0; i < 3000; i++) begin
            bus.valid = 1'($urandom % 2);
            bus.mode  = ($urandom % 4) != 0;
            bus.addr  = AW'($urandom % EN);
            for (int w = 0; w < VW / 32; w++) bus.data[w*32 +: 32] = $urandom;
            bus.rd_en   = 1'($urandom % 2);
            bus.addr_rd = AW'($urandom % EN);
            clear       = ($urandom % 64) == 0;
            cyc();
        end
        bus.valid = 0; bus.rd_en = 0; clear = 0;
        for (int i = 0; i < 20 && !bus.ready; i++) cyc();
        chk("rand_idle_ready", VW'(bus.ready), VW'(1));
        idle(2);

        // Reset with both stages occupied
        upd(1, 7, rep(9));
        bus.valid = 1; bus.mode = 1; bus.addr = 4'd7; bus.data = rep(9); bus.rd_en = 1;
        cyc();
        bus.valid = 0; bus.rd_en = 0;
        rst_n = 0;
        #1;
        chk("mid_rst_rd_valid", VW'(bus.rd_valid), VW'(0));
        chk("mid_rst_data_rd", bus.data_rd, VW'(0));
        chk("mid_rst_sat", VW'(sat), VW'(0));
        chk("mid_rst_busy", VW'(busy), VW'(0));
        chk("mid_rst_ready", VW'(bus.ready), VW'(1));
        cyc();
        rst_n = 1;
        idle(3);
        for (int a = 0; a < EN; a++) rd_lit(a, '0, "post_rst_entry");
        chk("post_rst_ready", VW'(bus.ready), VW'(1));
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
